instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage front end placed directly upstream of the pipelined datapath's IF/ID register.
//  Owns the fetch PC and issues in-order requests to a variable-latency instruction memory.
//  Buffers returned words with their PC in a DEPTH-entry queue; presents one instr/pc per cycle.
//  Flushes on branch redirect from the MEM stage and discards in-flight stale responses.
// PARAMETERS
//  DEPTH     4      queue entries, also max outstanding requests; power of 2, >=2
//  RESET_PC  32'h0  fetch PC loaded on reset
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  request address (= fetch PC)
//  imem_resp_valid in   1   response valid; responses return in request order, always accepted
//  imem_resp_data  in   32  response instruction word
//  redirect        in   1   branch taken (pcsrc), flush queue
//  redirect_pc     in   32  new fetch PC (pcbranch)
//  stall           in   1   datapath cannot consume this cycle
//  instr_valid     out  1   instr/pc_out valid
//  instr           out  32  instruction; 32'h0 (nop) when !instr_valid
//  pc_out          out  32  PC of instr
//  pcplus4         out  32  pc_out + 4 (mod 2^32)
//  perf_bubbles    out  32  see CONFIGURATION
//  perf_flushes    out  16  see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset=0, async): fetch_pc=RESET_PC, queue empty, drop_cnt=0, all outputs 0.
//  - Queue entry = {pc, data, filled}. Issue handshake: imem_req_valid && imem_req_ready.
//  - imem_req_valid = !redirect && (occupancy + drop_cnt < DEPTH); combinational.
//  - On issue: allocate tail entry {fetch_pc, -, filled=0}; fetch_pc += 4 (wraps at 2^32).
//  - On response (drop_cnt==0): data written into oldest unfilled entry, filled=1.
//  - Response with drop_cnt>0: discarded, drop_cnt -= 1.
//  - instr_valid = head.filled. Pop when instr_valid && !stall && !redirect.
//  - Min latency: issue cycle N, response N+k, instr_valid at N+k+1 (response registered).
//  - Redirect: next cycle fetch_pc=redirect_pc, queue empty; drop_cnt += number of issued-but-
//    unanswered entries (a same-cycle response counts as stale, dropped). No issue, no pop that cycle.
//  - Full (occupancy+drop_cnt==DEPTH): imem_req_valid=0 until a pop or a stale drop.
//  - Simultaneous issue+pop / response+pop: all applied; occupancy updates by net amount.
//  - stall holds head, instr/pc_out stable; issuing continues while credits remain.
//  - Reset mid-operation: everything returns to reset state; memory is reset by same signal.
//  - Response with nothing outstanding: ignored (assertion fires in simulation).
// CONFIGURATION
//  IFQ_PERF_EN defined: perf_bubbles += 1 each cycle with !stall && !instr_valid && !redirect;
//    perf_flushes += 1 per redirect; both saturate at all-ones, cleared by reset.
//  IFQ_PERF_EN undefined: perf_bubbles, perf_flushes tied to 0; no counter logic.
// TESTING
//  1 Reset RESET_PC=0x100, ready=1, 1-cycle memory -> addrs 0x100,0x104,..; pc_out 0x100 first, pcplus4 0x104.
//  2 stall=1 for 10 cycles, DEPTH=4 -> exactly 4 issues, then req_valid=0; instr/pc_out held.
//  3 3 requests outstanding, redirect to 0x400 -> next 3 responses dropped; first instr_valid has pc_out 0x400.
//  4 redirect same cycle as response and as head pop -> response dropped, head not popped, queue empty.
//  5 fetch_pc=0xFFFFFFFC -> next request addr 0x0; pcplus4 for that entry = 0x0.
//  6 IFQ_PERF_EN: 2 redirects, 5 starved cycles -> perf_flushes=2, perf_bubbles=5; undefined -> both 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests and queues returned words with their PC.
// Optional perf counters are built when IFQ_PERF_EN is defined; otherwise they read as zero.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pcplus4,
  output logic [31:0] perf_bubbles,
  output logic [15:0] perf_flushes
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW-1:0]    r_fill;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_pend;
  logic [CW-1:0]    r_drop;
  logic [31:0]      r_fetch_pc;

  logic [CW:0]      w_used;
  logic             w_issue;
  logic             w_resp_drop;
  logic             w_resp_fill;
  logic             w_pop;

  // Stale responses still hold a credit until they come back and are discarded.
  assign w_used         = {1'b0, r_count} + {1'b0, r_drop};
  assign imem_req_valid = reset && !redirect && (w_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_issue        = imem_req_valid && imem_req_ready;
  assign w_resp_drop    = imem_resp_valid && (r_drop != '0);
  assign w_resp_fill    = imem_resp_valid && (r_drop == '0) && (r_pend != '0);

  assign instr_valid = r_filled[r_head];
  assign w_pop       = instr_valid && !stall && !redirect;
  assign instr       = instr_valid ? r_data[r_head] : 32'h0;
  assign pc_out      = instr_valid ? r_pc[r_head] : 32'h0;
  assign pcplus4     = instr_valid ? r_pc[r_head] + 32'd4 : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      r_filled   <= '0;
    end else if (redirect) begin
      // Every unanswered request becomes stale, including one answered this very cycle.
      r_fetch_pc <= redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_filled   <= '0;
      r_drop     <= r_drop + r_pend - CW'(w_resp_drop || w_resp_fill);
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_tail     <= r_tail + 1'b1;
      end
      if (w_resp_fill) begin
        r_fill           <= r_fill + 1'b1;
        r_filled[r_fill] <= 1'b1;
      end
      if (w_pop) begin
        r_head           <= r_head + 1'b1;
        r_filled[r_head] <= 1'b0;
      end
      r_count <= r_count + CW'(w_issue) - CW'(w_pop);
      r_pend  <= r_pend + CW'(w_issue) - CW'(w_resp_fill);
      r_drop  <= r_drop - CW'(w_resp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue && !redirect) r_pc[r_tail] <= r_fetch_pc;
    if (w_resp_fill && !redirect) r_data[r_fill] <= imem_resp_data;
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_perf_bubbles;
  logic [15:0] r_perf_flushes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (!stall && !instr_valid && !redirect && (r_perf_bubbles != '1))
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (redirect && (r_perf_flushes != '1))
        r_perf_flushes <= r_perf_flushes + 16'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_flushes = r_perf_flushes;
`else
  assign perf_bubbles = 32'h0;
  assign perf_flushes = 16'h0;
`endif

  a_resp_outstanding: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> ((r_drop != '0) || (r_pend != '0)));

endmodule
